// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: takes a valid/ready byte stream and bit-bangs it MSB-first into a ccff chain.
// Optional feature macro CCFF_READBACK_CRC_EN adds readback_crc, a CRC-16-CCITT over the pre-shift ccff_tail bits.

module ccff_chain_loader #(
  parameter int CHAIN_LEN = 512,
  parameter int PRST_CYC  = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             prog_clk_o,
  output logic             prog_reset_o,
  output logic             ccff_head,
  input  logic             ccff_tail,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_count
`ifdef CCFF_READBACK_CRC_EN
  ,
  output logic [15:0]      readback_crc
`endif
);

  localparam int PC_W = (PRST_CYC > 1) ? $clog2(PRST_CYC) : 1;
  localparam logic [PC_W-1:0]  PRST_LAST = PC_W'(PRST_CYC - 1);
  localparam logic [CNT_W-1:0] CHAIN_END = CNT_W'(CHAIN_LEN);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRST  = 3'd1,
    FETCH = 3'd2,
    SLO   = 3'd3,
    SHI   = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [PC_W-1:0]  prst_cnt_r;
  logic [7:0]       byte_r;
  logic [2:0]       idx_r;
  logic [2:0]       idx_dec_s;
  logic             head_r;
  logic [CNT_W-1:0] bit_count_r;
  logic             done_r;
  logic             busy_r;
  logic             byte_ready_r;
  logic             prog_clk_r;
  logic             prog_reset_r;
  logic             launch_s;
  logic             load_s;
  logic             step_s;
  logic             shift_s;
  logic             finish_s;

  // Next-state decode plus one-cycle action strobes for the datapath.
  always_comb begin
    state_s   = state_r;
    launch_s  = 1'b0;
    load_s    = 1'b0;
    step_s    = 1'b0;
    shift_s   = 1'b0;
    finish_s  = 1'b0;
    idx_dec_s = idx_r - 3'd1;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s  = PRST;
          launch_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      PRST: begin
        if (prst_cnt_r == PRST_LAST) begin
          state_s = FETCH;
        end else begin
          state_s = PRST;
        end
      end
      FETCH: begin
        if (byte_valid && byte_ready_r) begin
          state_s = SLO;
          load_s  = 1'b1;
        end else begin
          state_s = FETCH;
        end
      end
      SLO: begin
        state_s = SHI;
        shift_s = 1'b1;
      end
      SHI: begin
        // bit_count_r already includes the bit being clocked in this cycle.
        if (bit_count_r == CHAIN_END) begin
          state_s  = IDLE;
          finish_s = 1'b1;
        end else if (idx_r == 3'd0) begin
          state_s = FETCH;
        end else begin
          state_s = SLO;
          step_s  = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register and state-decoded outputs, registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      prst_cnt_r   <= {PC_W{1'b0}};
      busy_r       <= 1'b0;
      byte_ready_r <= 1'b0;
      prog_clk_r   <= 1'b0;
      prog_reset_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      busy_r       <= (state_s != IDLE);
      byte_ready_r <= (state_s == FETCH);
      prog_clk_r   <= (state_s == SHI);
      prog_reset_r <= (state_s == PRST);
      if (state_r == PRST) begin
        prst_cnt_r <= prst_cnt_r + PC_W'(1);
      end else begin
        prst_cnt_r <= {PC_W{1'b0}};
      end
    end
  end

  // Byte holding register, bit index, serial head, progress counter and done flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_r      <= 8'h00;
      idx_r       <= 3'd0;
      head_r      <= 1'b0;
      bit_count_r <= {CNT_W{1'b0}};
      done_r      <= 1'b0;
    end else begin
      if (load_s) begin
        byte_r <= byte_data;
        idx_r  <= 3'd7;
        head_r <= byte_data[7];
      end else if (step_s) begin
        idx_r  <= idx_dec_s;
        head_r <= byte_r[idx_dec_s];
      end
      if (launch_s) begin
        bit_count_r <= {CNT_W{1'b0}};
      end else if (shift_s) begin
        bit_count_r <= bit_count_r + CNT_W'(1);
      end
      if (launch_s) begin
        done_r <= 1'b0;
      end else if (finish_s) begin
        done_r <= 1'b1;
      end
    end
  end

  assign byte_ready   = byte_ready_r;
  assign prog_clk_o   = prog_clk_r;
  assign prog_reset_o = prog_reset_r;
  assign ccff_head    = head_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign bit_count    = bit_count_r;

`ifdef CCFF_READBACK_CRC_EN
  logic [15:0] crc_r;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    crc16_step = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Tail is sampled on the edge entering SHI, i.e. before the chain shifts.
  always_ff @(posedge clk) begin
    if (reset) begin
      crc_r <= 16'hFFFF;
    end else if (launch_s) begin
      crc_r <= 16'hFFFF;
    end else if (shift_s) begin
      crc_r <= crc16_step(crc_r, ccff_tail);
    end
  end

  assign readback_crc = crc_r;
`else
  logic unused_tail_s;
  assign unused_tail_s = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: 16-bit and 12-bit chain instances, behavioural chain models, and
// a done-triggered scoreboard per instance.

module tb_ccff_chain_loader;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic        a_start, a_valid, a_ready, a_pclk, a_prst, a_head, a_tail, a_busy, a_done;
  logic [7:0]  a_data;
  logic [15:0] a_cnt;
  logic        b_start, b_valid, b_ready, b_pclk, b_prst, b_head, b_tail, b_busy, b_done;
  logic [7:0]  b_data;
  logic [15:0] b_cnt;
`ifdef CCFF_READBACK_CRC_EN
  logic [15:0] a_crc, b_crc;
`endif

  typedef struct {
    logic [15:0] chain;
    int          edges;
    logic [15:0] count;
    int          prst;
    int          cycles;
    logic        crc_chk;
    logic [15:0] crc;
  } exp_t;

  exp_t a_q[$];
  exp_t b_q[$];

  ccff_chain_loader #(.CHAIN_LEN(16), .PRST_CYC(4), .CNT_W(16)) u_dut16 (
    .clk(clk), .reset(reset), .start(a_start), .byte_data(a_data), .byte_valid(a_valid),
    .byte_ready(a_ready), .prog_clk_o(a_pclk), .prog_reset_o(a_prst), .ccff_head(a_head),
    .ccff_tail(a_tail), .busy(a_busy), .done(a_done), .bit_count(a_cnt)
`ifdef CCFF_READBACK_CRC_EN
    , .readback_crc(a_crc)
`endif
  );

  ccff_chain_loader #(.CHAIN_LEN(12), .PRST_CYC(4), .CNT_W(16)) u_dut12 (
    .clk(clk), .reset(reset), .start(b_start), .byte_data(b_data), .byte_valid(b_valid),
    .byte_ready(b_ready), .prog_clk_o(b_pclk), .prog_reset_o(b_prst), .ccff_head(b_head),
    .ccff_tail(b_tail), .busy(b_busy), .done(b_done), .bit_count(b_cnt)
`ifdef CCFF_READBACK_CRC_EN
    , .readback_crc(b_crc)
`endif
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  // Chain models: shift on prog_clk rise; prog_reset restarts the edge count and may clear data.
  logic [15:0] a_chain = 16'h0000;
  int          a_edges = 0;
  logic        a_clr_en = 1'b1;
  logic [11:0] b_chain = 12'h000;
  int          b_edges = 0;

  always @(posedge a_pclk or posedge a_prst) begin
    if (a_prst) begin
      a_edges <= 0;
      if (a_clr_en) a_chain <= 16'h0000;
    end else begin
      a_chain <= {a_chain[14:0], a_head};
      a_edges <= a_edges + 1;
    end
  end

  always @(posedge b_pclk or posedge b_prst) begin
    if (b_prst) begin
      b_edges <= 0;
      b_chain <= 12'h000;
    end else begin
      b_chain <= {b_chain[10:0], b_head};
      b_edges <= b_edges + 1;
    end
  end

  assign a_tail = a_chain[15];
  assign b_tail = b_chain[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] crc_ref(input logic [15:0] bits, input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = n - 1; i >= 0; i--) begin
      if (c[15] ^ bits[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // Monitor for the 16-bit instance: compares on each rising edge of done.
  initial begin
    logic a_done_prev;
    int   a_prst_run;
    exp_t e;
    a_done_prev = 1'b0;
    a_prst_run  = 0;
    forever begin
      @(negedge clk);
      if (a_done === 1'b1 && a_done_prev !== 1'b1) begin
        if (a_q.size() == 0) begin
          chk("a_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = a_q.pop_front();
          chk("a_chain", 32'(a_chain), 32'(e.chain));
          chk("a_edges", a_edges, e.edges);
          chk("a_bit_count", 32'(a_cnt), 32'(e.count));
          chk("a_prst_cycles", a_prst_run, e.prst);
          if (e.cycles >= 0) chk("a_done_cycle", cyc, e.cycles);
`ifdef CCFF_READBACK_CRC_EN
          if (e.crc_chk) chk("a_crc", 32'(a_crc), 32'(e.crc));
`endif
        end
      end
      if (a_busy !== 1'b1) a_prst_run = 0;
      else if (a_prst === 1'b1) a_prst_run++;
      a_done_prev = a_done;
    end
  end

  // Monitor for the 12-bit instance.
  initial begin
    logic b_done_prev;
    int   b_prst_run;
    exp_t e;
    b_done_prev = 1'b0;
    b_prst_run  = 0;
    forever begin
      @(negedge clk);
      if (b_done === 1'b1 && b_done_prev !== 1'b1) begin
        if (b_q.size() == 0) begin
          chk("b_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = b_q.pop_front();
          chk("b_chain", 32'(b_chain), 32'(e.chain));
          chk("b_edges", b_edges, e.edges);
          chk("b_bit_count", 32'(b_cnt), 32'(e.count));
          chk("b_prst_cycles", b_prst_run, e.prst);
          if (e.cycles >= 0) chk("b_done_cycle", cyc, e.cycles);
        end
      end
      if (b_busy !== 1'b1) b_prst_run = 0;
      else if (b_prst === 1'b1) b_prst_run++;
      b_done_prev = b_done;
    end
  end

  task automatic wait_ready(input bit sel);
    int n;
    n = 0;
    while (((sel ? b_ready : a_ready) !== 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if ((sel ? b_ready : a_ready) !== 1'b1) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input bit sel);
    int n;
    n = 0;
    while (!((sel ? b_done : a_done) === 1'b1 && (sel ? b_busy : a_busy) === 1'b0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if ((sel ? b_done : a_done) !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic a_load(input logic [7:0] d0, input logic [7:0] d1, input int stall,
                        input bit mid_start, input bit end_start,
                        input logic crc_chk, input logic [15:0] crc_exp);
    exp_t e;
    int   s;
    @(negedge clk);
    a_start = 1'b1;
    s = cyc + 1;
    e.chain = {d0, d1};
    e.edges = 16;
    e.count = 16'd16;
    e.prst = 4;
    e.cycles = s + 38 + stall;
    e.crc_chk = crc_chk;
    e.crc = crc_exp;
    a_q.push_back(e);
    if (end_start) begin
      fork
        begin
          int k;
          int target;
          k = 0;
          target = s + 37;
          while (cyc != target && k < 300) begin
            @(negedge clk);
            k++;
          end
          a_start = 1'b1;
          @(negedge clk);
          a_start = 1'b0;
        end
      join_none
    end
    @(negedge clk);
    a_start = 1'b0;
    a_data  = d0;
    a_valid = 1'b1;
    wait_ready(1'b0);
    @(negedge clk);
    if (stall > 0) begin
      a_valid = 1'b0;
      a_data  = d1;
      wait_ready(1'b0);
      repeat (stall) begin
        @(negedge clk);
        chk("a_stall_pclk", 32'(a_pclk), 32'd0);
        chk("a_stall_count", 32'(a_cnt), 32'd8);
      end
      a_valid = 1'b1;
    end else begin
      a_data = d1;
      if (mid_start) begin
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
      end
      wait_ready(1'b0);
    end
    @(negedge clk);
    a_valid = 1'b0;
    wait_idle(1'b0);
  endtask

  initial begin
    int   s;
    int   n;
    bit   seen;
    exp_t e;
    reset = 1'b1;
    a_start = 1'b0; a_valid = 1'b0; a_data = 8'h00;
    b_start = 1'b0; b_valid = 1'b0; b_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("a_reset_outs", 32'({a_ready, a_pclk, a_prst, a_head, a_busy, a_done, a_cnt}), 32'd0);
    chk("b_reset_outs", 32'({b_ready, b_pclk, b_prst, b_head, b_busy, b_done, b_cnt}), 32'd0);
`ifdef CCFF_READBACK_CRC_EN
    chk("a_reset_crc", 32'(a_crc), 32'h0000FFFF);
`endif
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Full-rate load, then the same load with a 10-cycle host stall between bytes.
    a_load(8'hA5, 8'h3C, 0, 1'b0, 1'b0, 1'b0, 16'h0000);
    a_load(8'hA5, 8'h3C, 10, 1'b0, 1'b0, 1'b0, 16'h0000);

    // 12-bit chain: second byte partly used, byte_ready must not come back.
    @(negedge clk);
    b_start = 1'b1;
    s = cyc + 1;
    e.chain = 16'h0FF0; e.edges = 12; e.count = 16'd12; e.prst = 4;
    e.cycles = s + 30; e.crc_chk = 1'b0; e.crc = 16'h0000;
    b_q.push_back(e);
    @(negedge clk);
    b_start = 1'b0;
    b_data  = 8'hFF;
    b_valid = 1'b1;
    wait_ready(1'b1);
    @(negedge clk);
    b_data = 8'h0F;
    wait_ready(1'b1);
    @(negedge clk);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (b_ready !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    chk("b_ready_after_last", 32'(seen), 32'd0);
    b_valid = 1'b0;
    chk("b_done_idle", 32'({b_done, b_busy}), 32'd2);

    // start pulses mid-load and on the completion edge are ignored.
    a_load(8'h5A, 8'hC3, 0, 1'b1, 1'b1, 1'b0, 16'h0000);
    repeat (6) @(negedge clk);
    chk("a_after_extra_start", 32'({a_done, a_busy, a_prst}), 32'd4);
    chk("a_after_extra_edges", a_edges, 16);

    // Reset at bit 5 aborts, then a fresh load completes normally.
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_data  = 8'hA5;
    a_valid = 1'b1;
    n = 0;
    while (a_cnt !== 16'd5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("a_reach_bit5", 32'(a_cnt), 32'd5);
    reset = 1'b1;
    @(negedge clk);
    chk("a_abort_outs", 32'({a_ready, a_pclk, a_prst, a_head, a_busy, a_done, a_cnt}), 32'd0);
    reset   = 1'b0;
    a_valid = 1'b0;
    a_load(8'hA5, 8'h3C, 0, 1'b0, 1'b0, 1'b0, 16'h0000);

`ifdef CCFF_READBACK_CRC_EN
    // Readback: chain loaded with zeros, then non-clearing reloads expose prior contents.
    a_load(8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b0, 16'h0000);
    a_clr_en = 1'b0;
    a_load(8'hA5, 8'h3C, 0, 1'b0, 1'b0, 1'b1, crc_ref(16'h0000, 16));
    a_load(8'hA5, 8'h3C, 0, 1'b0, 1'b0, 1'b1, crc_ref(16'hA53C, 16));
    repeat (5) @(negedge clk);
    chk("a_crc_hold", 32'(a_crc), 32'(crc_ref(16'hA53C, 16)));
    a_clr_en = 1'b1;
`endif

    repeat (4) @(negedge clk);
    chk("a_queue_drained", a_q.size(), 0);
    chk("b_queue_drained", b_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
